// File: rtl/sevenseg_scan_driver.sv
// Multiplexed common-anode seven-segment driver: valid/ready binary input, sequential
// double-dabble BCD conversion, leading-zero blanking, overflow dashes and a direction glyph.
module sevenseg_scan_driver #(
   parameter int unsigned N_DIGITS     = 4,
   parameter int unsigned VALUE_W      = 12,
   parameter int unsigned MODE_DIGIT   = 1,
   parameter int unsigned REFRESH_BITS = 18
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [VALUE_W-1:0]  VALUE,
   input  logic                VALUE_VALID,
   output logic                READY,
   input  logic                DIR,
   input  logic                BLANK_EN,
   output logic [6:0]          SEG,
   output logic [N_DIGITS-1:0] AN
);

   localparam int unsigned NUM   = N_DIGITS - MODE_DIGIT;
   localparam int unsigned BCD_D = (VALUE_W * 3) / 10 + 1;
   localparam int unsigned BCD_W = 4 * BCD_D;
   localparam int unsigned EXT_D = (NUM > BCD_D) ? NUM : BCD_D;
   localparam int unsigned IDX_W = $clog2(N_DIGITS);
   localparam int unsigned CNT_W = $clog2(VALUE_W + 1);

   typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

   state_e                  state_q, state_d;
   logic [VALUE_W-1:0]      bin_q, bin_d;
   logic [BCD_W-1:0]        bcd_q, bcd_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    ready_q, ready_d;
   logic [4*NUM-1:0]        disp_q, disp_d;
   logic                    ovf_q, ovf_d;
   logic                    dir_q;
   logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [6:0]              seg_q, seg_d;
   logic [N_DIGITS-1:0]     an_q, an_d;

   logic [BCD_W-1:0]        bcd_adj;
   logic [4*EXT_D-1:0]      bcd_ext;
   logic [3:0]              dig;
   logic                    nz;

   function automatic logic [6:0] bcd_glyph(input logic [3:0] d);
      case (d)
         4'd0:    bcd_glyph = 7'b1000000;
         4'd1:    bcd_glyph = 7'b1111001;
         4'd2:    bcd_glyph = 7'b0100100;
         4'd3:    bcd_glyph = 7'b0110000;
         4'd4:    bcd_glyph = 7'b0011001;
         4'd5:    bcd_glyph = 7'b0010010;
         4'd6:    bcd_glyph = 7'b0000010;
         4'd7:    bcd_glyph = 7'b1111000;
         4'd8:    bcd_glyph = 7'b0000000;
         4'd9:    bcd_glyph = 7'b0011000;
         default: bcd_glyph = 7'b1000000;
      endcase
   endfunction

   // Converter: one double-dabble step per cycle, then a single-cycle atomic commit.
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      ready_d = ready_q;
      disp_d  = disp_q;
      ovf_d   = ovf_q;
      bcd_adj = bcd_q;
      for (int i = 0; i < BCD_D; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      bcd_ext = '0;
      bcd_ext[BCD_W-1:0] = bcd_q;
      unique case (state_q)
         StIdle: begin
            if (VALUE_VALID) begin
               bin_d   = VALUE;
               bcd_d   = '0;
               cnt_d   = CNT_W'(VALUE_W);
               ready_d = 1'b0;
               state_d = StShift;
            end
         end
         StShift: begin
            {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_d = StCommit;
         end
         StCommit: begin
            disp_d  = bcd_ext[4*NUM-1:0];
            ovf_d   = |(bcd_ext >> (4 * NUM));
            ready_d = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Scan and glyph selection; SEG/AN are registered from the current index.
   always_comb begin
      refresh_d = refresh_q + 1'b1;
      idx_d     = idx_q;
      if (&refresh_q) begin
         idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
      for (int i = 0; i < N_DIGITS; i++) an_d[i] = (idx_q != IDX_W'(i));
      dig = '0;
      nz  = 1'b0;
      for (int i = 0; i < NUM; i++) begin
         if (idx_q == IDX_W'(i)) dig = disp_q[4*i +: 4];
         if (IDX_W'(i) >= idx_q && disp_q[4*i +: 4] != 4'd0) nz = 1'b1;
      end
      if (MODE_DIGIT != 0 && idx_q == IDX_W'(N_DIGITS - 1)) begin
         seg_d = dir_q ? 7'b0101111 : 7'b0001110;
      end else if (ovf_q) begin
         seg_d = 7'b0111111;
      end else if (BLANK_EN && idx_q != '0 && !nz) begin
         seg_d = 7'b1111111;
      end else begin
         seg_d = bcd_glyph(dig);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         bin_q     <= '0;
         bcd_q     <= '0;
         cnt_q     <= '0;
         ready_q   <= 1'b1;
         disp_q    <= '0;
         ovf_q     <= 1'b0;
         dir_q     <= 1'b0;
         refresh_q <= '0;
         idx_q     <= '0;
         seg_q     <= 7'h7F;
         an_q      <= '1;
      end else begin
         state_q   <= state_d;
         bin_q     <= bin_d;
         bcd_q     <= bcd_d;
         cnt_q     <= cnt_d;
         ready_q   <= ready_d;
         disp_q    <= disp_d;
         ovf_q     <= ovf_d;
         dir_q     <= DIR;
         refresh_q <= refresh_d;
         idx_q     <= idx_d;
         seg_q     <= seg_d;
         an_q      <= an_d;
      end
   end

   assign READY = ready_q;
   assign SEG   = seg_q;
   assign AN    = an_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Scoreboard bench: stimulus pushes expected values, per-instance monitors pop on READY rise
// and check a full scan against a decimal-arithmetic display model.
module tb_sevenseg_scan_driver;

   typedef struct {
      int value;
      bit dir;
      bit blank;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] value_a = '0;
   logic        valid_a = 1'b0, dir_a = 1'b0, blank_a = 1'b0;
   logic        ready_a;
   logic [6:0]  seg_a;
   logic [3:0]  an_a;
   logic [9:0]  value_b = '0;
   logic        valid_b = 1'b0, dir_b = 1'b0, blank_b = 1'b0;
   logic        ready_b;
   logic [6:0]  seg_b;
   logic [2:0]  an_b;

   int   checks = 0;
   int   failures = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   logic [6:0] glyph_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

   always #5 clk = ~clk;

   sevenseg_scan_driver #(
      .N_DIGITS(4), .VALUE_W(12), .MODE_DIGIT(1), .REFRESH_BITS(2)
   ) u_dut_a (
      .clk(clk), .rst_n(rst_n), .VALUE(value_a), .VALUE_VALID(valid_a), .READY(ready_a),
      .DIR(dir_a), .BLANK_EN(blank_a), .SEG(seg_a), .AN(an_a)
   );

   sevenseg_scan_driver #(
      .N_DIGITS(3), .VALUE_W(10), .MODE_DIGIT(0), .REFRESH_BITS(2)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n), .VALUE(value_b), .VALUE_VALID(valid_b), .READY(ready_b),
      .DIR(dir_b), .BLANK_EN(blank_b), .SEG(seg_b), .AN(an_b)
   );

   function automatic logic [6:0] exp_glyph(int value, int idx, bit dir, bit blank, int n,
                                            int mode);
      int num = n - mode;
      int p_idx = 1;
      int lim = 1;
      for (int k = 0; k < idx; k++) p_idx *= 10;
      for (int k = 0; k < num; k++) lim *= 10;
      if (mode == 1 && idx == n - 1) return dir ? 7'b0101111 : 7'b0001110;
      if (value >= lim) return 7'b0111111;
      if (blank && idx > 0 && value < p_idx) return 7'b1111111;
      return glyph_tab[(value / p_idx) % 10];
   endfunction

   task automatic check_scan(input int inst, input int value, input bit dir, input bit blank);
      int n = (inst == 0) ? 4 : 3;
      int mode = (inst == 0) ? 1 : 0;
      int prev = -1;
      int zeros, idx;
      logic [7:0] an;
      logic [6:0] seg, exp;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 4 * n + 4; s++) begin
         @(negedge clk);
         if (inst == 0) begin an = {4'hF, an_a}; seg = seg_a; end
         else begin an = {5'h1F, an_b}; seg = seg_b; end
         zeros = 0;
         idx = 0;
         for (int k = 0; k < n; k++) if (!an[k]) begin zeros++; idx = k; end
         checks++;
         if (zeros != 1) begin
            failures++;
            $display("FAIL an_onehot inst=%0d got=%b want exactly one low bit", inst, an);
         end else begin
            checks++;
            if (prev >= 0 && idx != prev && idx != (prev + 1) % n) begin
               failures++;
               $display("FAIL scan_order inst=%0d got idx=%0d after %0d", inst, idx, prev);
            end
            prev = idx;
            exp = exp_glyph(value, idx, dir, blank, n, mode);
            checks++;
            if (seg !== exp) begin
               failures++;
               $display("FAIL seg inst=%0d value=%0d idx=%0d got=%b want=%b", inst, value, idx,
                        seg, exp);
            end
         end
      end
   endtask

   // Monitors: a READY rise outside reset marks a completed conversion.
   initial begin : mon_a
      logic prev = 1'b1;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && ready_a === 1'b1 && !prev) begin
            checks++;
            if (q_a.size() == 0) begin
               failures++;
               $display("FAIL unexpected_done inst=0 got completion want none");
            end else begin
               e = q_a.pop_front();
               check_scan(0, e.value, e.dir, e.blank);
            end
         end
         prev = ready_a;
      end
   end

   initial begin : mon_b
      logic prev = 1'b1;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && ready_b === 1'b1 && !prev) begin
            checks++;
            if (q_b.size() == 0) begin
               failures++;
               $display("FAIL unexpected_done inst=1 got completion want none");
            end else begin
               e = q_b.pop_front();
               check_scan(1, e.value, e.dir, e.blank);
            end
         end
         prev = ready_b;
      end
   end

   task automatic send(input int inst, input int v, input bit dir, input bit blank,
                       input bit drop);
      exp_t e;
      int low = 0;
      int want = (inst == 0) ? 13 : 11;
      e.value = v;
      e.dir = dir;
      e.blank = blank;
      if (inst == 0) begin dir_a = dir; blank_a = blank; end
      else begin dir_b = dir; blank_b = blank; end
      repeat (3) @(negedge clk);
      if (inst == 0) begin q_a.push_back(e); value_a = 12'(v); valid_a = 1'b1; end
      else begin q_b.push_back(e); value_b = 10'(v); valid_b = 1'b1; end
      @(negedge clk);
      valid_a = 1'b0;
      valid_b = 1'b0;
      while (((inst == 0) ? !ready_a : !ready_b) && low < 100) begin
         low++;
         if (drop && low == 4) begin value_a = 12'd999; valid_a = 1'b1; end
         if (drop && low == 5) valid_a = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (low != want) begin
         failures++;
         $display("FAIL ready_low inst=%0d value=%0d got=%0d cycles want=%0d", inst, v, low,
                  want);
      end
      repeat (30) @(negedge clk);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL timeout got no finish want finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int v;
      logic [3:0] want_an;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks += 4;
      if (an_a !== 4'hF) begin failures++; $display("FAIL reset_an got=%b want=1111", an_a); end
      if (seg_a !== 7'h7F) begin failures++; $display("FAIL reset_seg got=%b want=1111111", seg_a); end
      if (ready_a !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", ready_a); end
      if (an_b !== 3'b111) begin failures++; $display("FAIL reset_an_b got=%b want=111", an_b); end
      rst_n = 1'b1;
      for (int j = 0; j < 17; j++) begin
         @(negedge clk);
         want_an = ~(4'b0001 << ((j / 4) % 4));
         checks++;
         if (an_a !== want_an) begin
            failures++;
            $display("FAIL an_seq step=%0d got=%b want=%b", j, an_a, want_an);
         end
      end

      send(0, 427, 1'b0, 1'b0, 1'b0);
      send(0, 427, 1'b1, 1'b0, 1'b0);
      send(0, 5, 1'b0, 1'b1, 1'b0);
      send(0, 5, 1'b0, 1'b0, 1'b0);
      send(0, 0, 1'b0, 1'b1, 1'b0);
      send(0, 1234, 1'b1, 1'b0, 1'b0);
      send(0, 42, 1'b0, 1'b1, 1'b1);
      send(0, 4095, 1'b0, 1'b0, 1'b0);
      send(0, 999, 1'b1, 1'b1, 1'b0);
      for (int t = 0; t < 14; t++) begin
         v = $urandom_range(0, 1) ? int'($urandom_range(0, 120)) : int'($urandom_range(0, 4095));
         send(0, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end

      send(1, 1023, 1'b0, 1'b0, 1'b0);
      send(1, 7, 1'b0, 1'b1, 1'b0);
      for (int t = 0; t < 5; t++) begin
         send(1, int'($urandom_range(0, 1023)), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end

      // Abort a conversion of 300 over a displayed 100.
      send(0, 100, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      value_a = 12'd300;
      valid_a = 1'b1;
      @(negedge clk);
      valid_a = 1'b0;
      checks++;
      if (ready_a !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b want=0", ready_a); end
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if (ready_a !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b want=1", ready_a); end
      check_scan(0, 0, 1'b0, 1'b0);
      repeat (40) @(negedge clk);

      checks++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         failures++;
         $display("FAIL queue_drain got=%0d/%0d want=0/0", q_a.size(), q_b.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
